if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 43 ++++
 rtl/if_stage.sv | 83 ++++++++
 tb/tb_if_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-fetch stage bus: fetch control, imem port, ID redirects, IF/ID register outputs.
// Latency: none (signal bundle only).
// Backpressure: stall_i from the environment holds the stage; there is no ready/valid return path.
// Optional counters cycle_cnt_o/stall_cnt_o/flush_cnt_o exist only when IF_PERF_CNT_EN is defined.
// master = the fetch stage, slave = the surrounding core / testbench.
interface if_stage_if;
    logic        start_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        branch_i;
    logic        branch_eq_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_next_addr_o;
    logic        ifid_valid_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] cycle_cnt_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    modport master (
        input  start_i, imem_data_i, stall_i, jump_i, jump_target_i,
               branch_i, branch_eq_i, branch_target_i,
        output imem_addr_o, pc_o, ifid_instr_o, ifid_next_addr_o, ifid_valid_o
`ifdef IF_PERF_CNT_EN
        , output cycle_cnt_o, stall_cnt_o, flush_cnt_o
`endif
    );

    modport slave (
        output start_i, imem_data_i, stall_i, jump_i, jump_target_i,
               branch_i, branch_eq_i, branch_target_i,
        input  imem_addr_o, pc_o, ifid_instr_o, ifid_next_addr_o, ifid_valid_o
`ifdef IF_PERF_CNT_EN
        , input cycle_cnt_o, stall_cnt_o, flush_cnt_o
`endif
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, redirect/stall/idle control and the IF/ID pipeline register.
// Latency: one cycle from fetch (imem_addr_o = pc) to the IF/ID register.
// Backpressure: stall_i holds PC and IF/ID; a redirect overrides a stall; start_i low freezes PC and issues bubbles.
// Ports: clk_i, rst_i (async active-low) plus the if_stage_if master modport.
// Optional macro IF_PERF_CNT_EN adds saturating cycle/stall/flush counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    if_stage_if.master   bus
);

    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_next_addr;
    logic        ifid_valid;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Jump has priority over a simultaneously taken branch.
    assign redirect = bus.jump_i | (bus.branch_i & bus.branch_eq_i);
    assign target   = bus.jump_i ? bus.jump_target_i : bus.branch_target_i;
    // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc             <= RESET_PC;
            ifid_instr     <= 32'h0;
            ifid_next_addr <= 32'h0;
            ifid_valid     <= 1'b0;
        end else if (!bus.start_i) begin
            ifid_instr     <= 32'h0;
            ifid_next_addr <= 32'h0;
            ifid_valid     <= 1'b0;
        end else if (redirect) begin
            // The instruction fetched this cycle is on the wrong path: flush it.
            pc             <= target;
            ifid_instr     <= 32'h0;
            ifid_next_addr <= 32'h0;
            ifid_valid     <= 1'b0;
        end else if (!bus.stall_i) begin
            pc             <= pc_plus4;
            ifid_instr     <= bus.imem_data_i;
            ifid_next_addr <= pc_plus4;
            ifid_valid     <= 1'b1;
        end
    end

    assign bus.imem_addr_o      = pc;
    assign bus.pc_o             = pc;
    assign bus.ifid_instr_o     = ifid_instr;
    assign bus.ifid_next_addr_o = ifid_next_addr;
    assign bus.ifid_valid_o     = ifid_valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycle_cnt <= 32'h0;
            stall_cnt <= 32'h0;
            flush_cnt <= 32'h0;
        end else if (bus.start_i) begin
            if (cycle_cnt != 32'hFFFF_FFFF)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (bus.stall_i && !redirect && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (redirect && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign bus.cycle_cnt_o = cycle_cnt;
    assign bus.stall_cnt_o = stall_cnt;
    assign bus.flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   checks = 0;
    int   errors = 0;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory contents: fixed word at 0, hashed words elsewhere.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0) return 32'h2002_0005;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    always_comb bus.imem_data_i = mem_f(bus.imem_addr_o);

    // Reference model state (architectural view of the stage).
    logic [31:0] m_pc, m_instr, m_next;
    logic        m_valid;
    logic [31:0] m_cyc, m_stl, m_fls;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_next = 32'h0; m_valid = 1'b0;
        m_cyc = 32'h0; m_stl = 32'h0; m_fls = 32'h0;
    endtask

    // Drive one cycle of inputs at negedge, clock it, advance the model, settle #1.
    task automatic step(input logic s, input logic st, input logic j, input logic [31:0] jt,
                        input logic b, input logic be, input logic [31:0] bt);
        bit taken;
        @(negedge clk_i);
        bus.start_i = s; bus.stall_i = st; bus.jump_i = j; bus.jump_target_i = jt;
        bus.branch_i = b; bus.branch_eq_i = be; bus.branch_target_i = bt;
        @(posedge clk_i);
        taken = j || (b && be);
        if (!s) begin
            m_instr = 0; m_next = 0; m_valid = 0;
        end else begin
            m_cyc = sat_inc(m_cyc);
            if (taken) begin
                m_pc = j ? jt : bt;
                m_instr = 0; m_next = 0; m_valid = 0;
                m_fls = sat_inc(m_fls);
            end else if (st) begin
                m_stl = sat_inc(m_stl);
            end else begin
                m_instr = mem_f(m_pc);
                m_next = m_pc + 32'd4;
                m_valid = 1;
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic fetch();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        bus.start_i = 0; bus.stall_i = 0; bus.jump_i = 0; bus.jump_target_i = 0;
        bus.branch_i = 0; bus.branch_eq_i = 0; bus.branch_target_i = 0;
        rst_i = 0;
        model_reset();
        #12;
        checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.pc_o, 32'h0); end
        checks++; if (bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_imem_addr: got %h expected %h", bus.imem_addr_o, 32'h0); end
        checks++; if (bus.ifid_instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", bus.ifid_instr_o, 32'h0); end
        checks++; if (bus.ifid_next_addr_o !== 32'h0) begin errors++; $display("FAIL reset_next: got %h expected %h", bus.ifid_next_addr_o, 32'h0); end
        checks++; if (bus.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.ifid_valid_o); end
`ifdef IF_PERF_CNT_EN
        checks++; if (bus.cycle_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_cycle_cnt: got %h expected 0", bus.cycle_cnt_o); end
`endif
        @(negedge clk_i);
        rst_i = 1;
    endtask

    task automatic test_fetch();
        fetch();
        checks++; if (bus.pc_o !== 32'd4) begin errors++; $display("FAIL fetch_pc: got %h expected %h", bus.pc_o, 32'd4); end
        checks++; if (bus.ifid_instr_o !== 32'h2002_0005) begin errors++; $display("FAIL fetch_instr: got %h expected %h", bus.ifid_instr_o, 32'h2002_0005); end
        checks++; if (bus.ifid_next_addr_o !== 32'd4) begin errors++; $display("FAIL fetch_next: got %h expected %h", bus.ifid_next_addr_o, 32'd4); end
        checks++; if (bus.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b expected 1", bus.ifid_valid_o); end
    endtask

    task automatic test_stall();
        logic [31:0] stl0;
        fetch(); // pc now 8, IF/ID holds word at 4
        stl0 = m_stl;
        for (int k = 0; k < 2; k++) begin
            step(1, 1, 0, 0, 0, 0, 0);
            checks++; if (bus.pc_o !== 32'd8) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", k, bus.pc_o, 32'd8); end
            checks++; if (bus.ifid_instr_o !== mem_f(32'd4) || bus.ifid_next_addr_o !== 32'd8 || bus.ifid_valid_o !== 1'b1) begin
                errors++; $display("FAIL stall_ifid[%0d]: got %h/%h/%b expected %h/%h/1", k,
                                   bus.ifid_instr_o, bus.ifid_next_addr_o, bus.ifid_valid_o, mem_f(32'd4), 32'd8);
            end
        end
`ifdef IF_PERF_CNT_EN
        checks++; if (bus.stall_cnt_o !== stl0 + 32'd2) begin errors++; $display("FAIL stall_cnt: got %0d expected %0d", bus.stall_cnt_o, stl0 + 32'd2); end
`endif
    endtask

    task automatic test_branch();
        logic [31:0] f0;
        fetch(); // pc 12
        step(1, 0, 0, 0, 1, 0, 32'd40); // not taken
        checks++; if (bus.pc_o !== 32'd16 || bus.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL branch_not_taken: got pc %h valid %b expected %h 1", bus.pc_o, bus.ifid_valid_o, 32'd16); end
        checks++; if (bus.ifid_instr_o !== mem_f(32'd12)) begin errors++; $display("FAIL branch_not_taken_instr: got %h expected %h", bus.ifid_instr_o, mem_f(32'd12)); end
        step(1, 0, 1, 32'd12, 0, 0, 0); // back to pc 12
        f0 = m_fls;
        step(1, 0, 0, 0, 1, 1, 32'd40);
        checks++; if (bus.pc_o !== 32'd40) begin errors++; $display("FAIL branch_taken_pc: got %h expected %h", bus.pc_o, 32'd40); end
        checks++; if (bus.ifid_instr_o !== 32'h0 || bus.ifid_valid_o !== 1'b0 || bus.ifid_next_addr_o !== 32'h0) begin
            errors++; $display("FAIL branch_flush: got %h/%h/%b expected 0/0/0", bus.ifid_instr_o, bus.ifid_next_addr_o, bus.ifid_valid_o);
        end
`ifdef IF_PERF_CNT_EN
        checks++; if (bus.flush_cnt_o !== f0 + 32'd1) begin errors++; $display("FAIL branch_flush_cnt: got %0d expected %0d", bus.flush_cnt_o, f0 + 32'd1); end
`endif
    endtask

    task automatic test_jump_priority();
        logic [31:0] f0, s0;
        fetch();
        f0 = m_fls; s0 = m_stl;
        step(1, 1, 1, 32'd64, 1, 1, 32'd40);
        checks++; if (bus.pc_o !== 32'd64) begin errors++; $display("FAIL jump_prio_pc: got %h expected %h", bus.pc_o, 32'd64); end
        checks++; if (bus.ifid_valid_o !== 1'b0 || bus.ifid_instr_o !== 32'h0) begin errors++; $display("FAIL jump_prio_flush: got %h/%b expected 0/0", bus.ifid_instr_o, bus.ifid_valid_o); end
`ifdef IF_PERF_CNT_EN
        checks++; if (bus.flush_cnt_o !== f0 + 32'd1) begin errors++; $display("FAIL jump_prio_flush_cnt: got %0d expected %0d", bus.flush_cnt_o, f0 + 32'd1); end
        checks++; if (bus.stall_cnt_o !== s0) begin errors++; $display("FAIL jump_prio_stall_cnt: got %0d expected %0d", bus.stall_cnt_o, s0); end
`endif
        // Unaligned target is used as-is.
        step(1, 0, 1, 32'h0000_0103, 0, 0, 0);
        checks++; if (bus.pc_o !== 32'h0000_0103) begin errors++; $display("FAIL jump_unaligned: got %h expected %h", bus.pc_o, 32'h0000_0103); end
    endtask

    task automatic test_wrap();
        step(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        fetch();
        checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", bus.pc_o); end
        checks++; if (bus.ifid_next_addr_o !== 32'h0 || bus.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL wrap_ifid: got %h/%b expected 0/1", bus.ifid_next_addr_o, bus.ifid_valid_o); end
        checks++; if (bus.ifid_instr_o !== mem_f(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_instr: got %h expected %h", bus.ifid_instr_o, mem_f(32'hFFFF_FFFC)); end
    endtask

    task automatic test_start_low();
        fetch();
        step(0, 0, 1, 32'd200, 0, 0, 0); // redirect ignored while idle
        checks++; if (bus.pc_o !== m_pc || bus.ifid_valid_o !== 1'b0 || bus.ifid_instr_o !== 32'h0) begin
            errors++; $display("FAIL start_low: got pc %h valid %b instr %h expected pc %h 0 0", bus.pc_o, bus.ifid_valid_o, bus.ifid_instr_o, m_pc);
        end
`ifdef IF_PERF_CNT_EN
        checks++; if (bus.cycle_cnt_o !== m_cyc) begin errors++; $display("FAIL start_low_cycle_cnt: got %0d expected %0d", bus.cycle_cnt_o, m_cyc); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] jt, bt;
        for (int n = 0; n < 300; n++) begin
            jt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4) : $urandom_range(0, 1023) * 4;
            bt = $urandom;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, jt,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, bt);
            checks++;
            if (bus.pc_o !== m_pc || bus.imem_addr_o !== m_pc || bus.ifid_instr_o !== m_instr ||
                bus.ifid_next_addr_o !== m_next || bus.ifid_valid_o !== m_valid) begin
                errors++; $display("FAIL random[%0d]: got pc %h addr %h ifid %h/%h/%b expected pc %h ifid %h/%h/%b", n,
                                   bus.pc_o, bus.imem_addr_o, bus.ifid_instr_o, bus.ifid_next_addr_o, bus.ifid_valid_o,
                                   m_pc, m_instr, m_next, m_valid);
            end
`ifdef IF_PERF_CNT_EN
            checks++;
            if (bus.cycle_cnt_o !== m_cyc || bus.stall_cnt_o !== m_stl || bus.flush_cnt_o !== m_fls) begin
                errors++; $display("FAIL random_cnt[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", n,
                                   bus.cycle_cnt_o, bus.stall_cnt_o, bus.flush_cnt_o, m_cyc, m_stl, m_fls);
            end
`endif
        end
    endtask

    task automatic test_reset_mid_stall();
        step(1, 0, 1, 32'd20, 0, 0, 0);
        fetch();                        // pc 24, IF/ID valid
        step(1, 0, 1, 32'd20, 0, 0, 0); // pc 20, flushed
        fetch();                        // pc 24
        step(1, 0, 1, 32'd20, 0, 0, 0); // pc 20
        @(negedge clk_i);
        bus.stall_i = 1; bus.jump_i = 0; bus.branch_i = 0;
        @(posedge clk_i);
        #3;
        rst_i = 0;
        model_reset();
        #1;
        checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL async_reset_pc: got %h expected 0", bus.pc_o); end
        checks++; if (bus.ifid_instr_o !== 32'h0 || bus.ifid_next_addr_o !== 32'h0 || bus.ifid_valid_o !== 1'b0) begin
            errors++; $display("FAIL async_reset_ifid: got %h/%h/%b expected 0/0/0", bus.ifid_instr_o, bus.ifid_next_addr_o, bus.ifid_valid_o);
        end
`ifdef IF_PERF_CNT_EN
        checks++; if (bus.cycle_cnt_o !== 0 || bus.stall_cnt_o !== 0 || bus.flush_cnt_o !== 0) begin
            errors++; $display("FAIL async_reset_cnt: got %0d/%0d/%0d expected 0/0/0", bus.cycle_cnt_o, bus.stall_cnt_o, bus.flush_cnt_o);
        end
`endif
        @(negedge clk_i);
        rst_i = 1;
        fetch();
        checks++; if (bus.pc_o !== 32'd4 || bus.ifid_instr_o !== 32'h2002_0005 || bus.ifid_valid_o !== 1'b1) begin
            errors++; $display("FAIL post_reset_fetch: got pc %h instr %h valid %b expected %h %h 1", bus.pc_o, bus.ifid_instr_o, bus.ifid_valid_o, 32'd4, 32'h2002_0005);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_jump_priority();
        test_wrap();
        test_start_low();
        test_random();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
